// File: rtl/sparc_exu_ecc_errlog_if.sv
// ----------------------------------------------------------------------------
// sparc_exu_ecc_errlog_if
//   Report channel from the IRF ECC error logger to the IFU trap/ESR logic.
//   One report names a thread that holds a logged error. rpt_ue always shows
//   the thread's current log state, so a CE report can turn into a UE report
//   while it waits for rpt_rdy.
//
//   Signals
//     rpt_vld  logger -> IFU  a report is available
//     rpt_rdy  IFU -> logger  IFU accepts the report this cycle
//     rpt_tid  logger -> IFU  thread being reported
//     rpt_ue   logger -> IFU  the reported thread's log holds a UE
//
//   Modports
//     master : logger side (drives vld/tid/ue, samples rdy)
//     slave  : IFU side    (samples vld/tid/ue, drives rdy)
// ----------------------------------------------------------------------------
interface sparc_exu_ecc_errlog_if;
    logic       rpt_vld;
    logic       rpt_rdy;
    logic [1:0] rpt_tid;
    logic       rpt_ue;

    modport master (output rpt_vld, output rpt_tid, output rpt_ue, input rpt_rdy);
    modport slave  (input rpt_vld, input rpt_tid, input rpt_ue, output rpt_rdy);
endinterface

// File: rtl/sparc_exu_ecc_errlog.sv
// ----------------------------------------------------------------------------
// sparc_exu_ecc_errlog
//   Per-thread IRF ECC error logger. It sits behind the EXU ECC control stage.
//   The M-stage CE/UE flags, register id and syndrome are flopped into W.
//   Flushed instructions are dropped. Each thread keeps one first-error log,
//   a multiple-error bit and a saturating CE counter. A small FIFO holds at
//   most one report per thread for the IFU.
//
//   Ports
//     clk, arst_l              core clock, asynchronous active-low reset
//     exu_ifu_ecc_ce_m/ue_m    CE / UE flags of the M-stage instruction
//     exu_ifu_err_reg_m[7:0]   {window/gl[2:0], reg[4:0]} of the failing source
//     exu_ifu_err_synd_7_m     syndrome bit 7 (1 = true CE)
//     ecc_errlog_synd_m[6:0]   syndrome bits [6:0] from the ECC decoder
//     ifu_exu_tid_m[1:0]       thread of the M-stage instruction
//     ifu_exu_flush_w          the W-stage instruction is flushed
//     clr_vld, clr_tid         software clear of one thread's log and counter
//     rpt                      report handshake to the IFU (master modport)
//     log_rd_tid, log_rd_data  combinational read, {vld, ue, me, reg, synd}
//     ce_thresh_hit[NTHR-1:0]  per-thread CE count >= CE_THRESH
// ----------------------------------------------------------------------------
module sparc_exu_ecc_errlog #(
    parameter int NTHR      = 4,
    parameter int CE_CNT_W  = 4,
    parameter int CE_THRESH = 8
) (
    input  logic                   clk,
    input  logic                   arst_l,
    input  logic                   exu_ifu_ecc_ce_m,
    input  logic                   exu_ifu_ecc_ue_m,
    input  logic [7:0]             exu_ifu_err_reg_m,
    input  logic                   exu_ifu_err_synd_7_m,
    input  logic [6:0]             ecc_errlog_synd_m,
    input  logic [1:0]             ifu_exu_tid_m,
    input  logic                   ifu_exu_flush_w,
    input  logic                   clr_vld,
    input  logic [1:0]             clr_tid,
    sparc_exu_ecc_errlog_if.master rpt,
    input  logic [1:0]             log_rd_tid,
    output logic [18:0]            log_rd_data,
    output logic [NTHR-1:0]        ce_thresh_hit
);

    localparam int TID_W  = 2;
    localparam int FIFO_D = 4;
    localparam logic [CE_CNT_W-1:0] CNT_MAX = '1;

    // Field order matches the log_rd_data layout.
    typedef struct packed {
        logic       vld;
        logic       ue;
        logic       me;
        logic [7:0] err_reg;
        logic [7:0] synd;
    } log_t;

    // ------------------------------------------------------------------
    // M -> W pipe flops
    // ------------------------------------------------------------------
    logic             ce_w;
    logic             ue_w;
    logic [7:0]       reg_w;
    logic [7:0]       synd_w;
    logic [TID_W-1:0] tid_w;

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            ce_w   <= 1'b0;
            ue_w   <= 1'b0;
            reg_w  <= '0;
            synd_w <= '0;
            tid_w  <= '0;
        end else begin
            ce_w   <= exu_ifu_ecc_ce_m;
            ue_w   <= exu_ifu_ecc_ue_m;
            reg_w  <= exu_ifu_err_reg_m;
            synd_w <= {exu_ifu_err_synd_7_m, ecc_errlog_synd_m};
            tid_w  <= ifu_exu_tid_m;
        end
    end

    logic log_w;
    logic ce_only_w;

    assign log_w     = (ce_w | ue_w) & ~ifu_exu_flush_w;
    assign ce_only_w = ce_w & ~ue_w;  // a UE masks a CE from the same access

    // ------------------------------------------------------------------
    // Per-thread logs and CE counters
    // ------------------------------------------------------------------
    log_t [NTHR-1:0]               log_q,  log_d;
    logic [NTHR-1:0][CE_CNT_W-1:0] cnt_q,  cnt_d;
    logic [NTHR-1:0]               event_v;

    // A clear is applied first. An error for the same thread in the same
    // cycle then lands on an empty log and counter, as a fresh capture.
    // NOTE: every signal written here gets a default at the top of the block,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        log_d   = log_q;
        cnt_d   = cnt_q;
        event_v = '0;
        for (int t = 0; t < NTHR; t++) begin
            if (clr_vld && clr_tid == TID_W'(t)) begin
                log_d[t] = '0;
                cnt_d[t] = '0;
            end
            if (log_w && tid_w == TID_W'(t)) begin
                if (!log_d[t].vld) begin
                    log_d[t].vld     = 1'b1;
                    log_d[t].ue      = ue_w;
                    log_d[t].me      = 1'b0;
                    log_d[t].err_reg = reg_w;
                    log_d[t].synd    = synd_w;
                    event_v[t]       = 1'b1;
                end else if (!log_d[t].ue && ue_w) begin
                    // A UE replaces a logged CE. The log records the worse error.
                    log_d[t].ue      = 1'b1;
                    log_d[t].me      = 1'b1;
                    log_d[t].err_reg = reg_w;
                    log_d[t].synd    = synd_w;
                    event_v[t]       = 1'b1;
                end else begin
                    log_d[t].me = 1'b1;
                end
                if (ce_only_w && cnt_d[t] != CNT_MAX) begin
                    cnt_d[t] = cnt_d[t] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            log_q <= '0;
            cnt_q <= '0;
        end else begin
            log_q <= log_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        ce_thresh_hit = '0;
        for (int t = 0; t < NTHR; t++) begin
            ce_thresh_hit[t] = (int'(cnt_q[t]) >= CE_THRESH);
        end
    end

    assign log_rd_data = log_q[log_rd_tid];

    // ------------------------------------------------------------------
    // Report FIFO. Each thread has at most one entry (pending bit), so
    // NTHR entries can never overflow.
    // ------------------------------------------------------------------
    logic [TID_W-1:0] fifo_mem [FIFO_D];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [2:0]       fifo_cnt;
    logic [NTHR-1:0]  pending_q;
    logic [NTHR-1:0]  deq_v;
    logic [NTHR-1:0]  enq_v;
    logic [TID_W-1:0] head_tid;
    logic             fifo_ne;
    logic             head_live;
    logic             deq;
    logic             enq;

    assign head_tid  = fifo_mem[rd_ptr];
    assign fifo_ne   = (fifo_cnt != 3'd0);
    assign head_live = log_q[head_tid].vld;
    // A head whose log was cleared is stale. It is dropped without a report.
    assign deq       = fifo_ne & (~head_live | rpt.rpt_rdy);

    always_comb begin
        deq_v = '0;
        if (deq) begin
            deq_v[head_tid] = 1'b1;
        end
    end

    // A thread that is popping this cycle can queue again at once.
    assign enq_v = event_v & (~pending_q | deq_v);
    assign enq   = |enq_v;

    // NOTE: the FIFO storage is reset with the pointers. The head entry then
    // reads as thread 0 after reset, so rpt_tid and rpt_ue come out of reset at 0.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_cnt  <= '0;
            pending_q <= '0;
        end else begin
            if (enq) begin
                fifo_mem[wr_ptr] <= tid_w;  // only the W-stage thread can have an event
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (enq && !deq) begin
                fifo_cnt <= fifo_cnt + 3'd1;
            end else if (deq && !enq) begin
                fifo_cnt <= fifo_cnt - 3'd1;
            end
            pending_q <= (pending_q & ~deq_v) | enq_v;
        end
    end

    assign rpt.rpt_vld = fifo_ne & head_live;
    assign rpt.rpt_tid = head_tid;
    assign rpt.rpt_ue  = log_q[head_tid].ue;  // live value, so an upgrade shows

endmodule

// File: tb/tb_sparc_exu_ecc_errlog.sv
// ----------------------------------------------------------------------------
// tb_sparc_exu_ecc_errlog
//   Directed and random stimulus for sparc_exu_ecc_errlog. The reference model
//   keeps per-thread logs, counters and a queue of thread ids, and advances
//   once per clock from the logging rules.
// ----------------------------------------------------------------------------
module tb_sparc_exu_ecc_errlog;

    logic       clk = 1'b0;
    logic       arst_l;
    logic       ce_m, ue_m, synd7_m, flush_w, clr_vld;
    logic [7:0] err_reg_m;
    logic [6:0] synd_m;
    logic [1:0] tid_m, clr_tid, log_rd_tid;
    logic [18:0] log_rd_data;
    logic [3:0] ce_thresh_hit;

    sparc_exu_ecc_errlog_if rif ();

    sparc_exu_ecc_errlog dut (
        .clk                  (clk),
        .arst_l               (arst_l),
        .exu_ifu_ecc_ce_m     (ce_m),
        .exu_ifu_ecc_ue_m     (ue_m),
        .exu_ifu_err_reg_m    (err_reg_m),
        .exu_ifu_err_synd_7_m (synd7_m),
        .ecc_errlog_synd_m    (synd_m),
        .ifu_exu_tid_m        (tid_m),
        .ifu_exu_flush_w      (flush_w),
        .clr_vld              (clr_vld),
        .clr_tid              (clr_tid),
        .rpt                  (rif),
        .log_rd_tid           (log_rd_tid),
        .log_rd_data          (log_rd_data),
        .ce_thresh_hit        (ce_thresh_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit       vld;
        bit       ue;
        bit       me;
        bit [7:0] rg;
        bit [7:0] synd;
    } mlog_t;

    mlog_t    mlog [4];
    int       mcnt [4];
    int       q [$];
    bit       pend [4];
    bit       w_ce, w_ue;
    bit [7:0] w_reg, w_synd;
    int       w_tid;

    function automatic void model_reset();
        for (int t = 0; t < 4; t++) begin
            mlog[t] = '{default: 0};
            mcnt[t] = 0;
            pend[t] = 1'b0;
        end
        q.delete();
        w_ce = 0; w_ue = 0; w_reg = 0; w_synd = 0; w_tid = 0;
    endfunction

    // Advances the model across one rising edge, using the current inputs.
    function automatic void model_step();
        bit popped = 1'b0;
        int h = 0;
        bit ev = 1'b0;
        bit old_pend;
        // The report decision uses the logs as they are before this edge.
        if (q.size() > 0) begin
            h = q[0];
            if (!mlog[h].vld || rif.rpt_rdy) begin
                void'(q.pop_front());
                popped = 1'b1;
            end
        end
        if (clr_vld) begin
            mlog[clr_tid] = '{default: 0};
            mcnt[clr_tid] = 0;
        end
        if ((w_ce || w_ue) && !flush_w) begin
            if (!mlog[w_tid].vld) begin
                mlog[w_tid] = '{vld: 1, ue: w_ue, me: 0, rg: w_reg, synd: w_synd};
                ev = 1'b1;
            end else if (w_ue && !mlog[w_tid].ue) begin
                mlog[w_tid] = '{vld: 1, ue: 1, me: 1, rg: w_reg, synd: w_synd};
                ev = 1'b1;
            end else begin
                mlog[w_tid].me = 1'b1;
            end
            if (w_ce && !w_ue && mcnt[w_tid] < 15) mcnt[w_tid]++;
        end
        old_pend = pend[w_tid];
        if (popped) pend[h] = 1'b0;
        if (ev && (!old_pend || (popped && h == w_tid))) begin
            q.push_back(w_tid);
            pend[w_tid] = 1'b1;
        end
        w_ce = ce_m; w_ue = ue_m; w_reg = err_reg_m; w_synd = {synd7_m, synd_m};
        w_tid = int'(tid_m);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_log(input int t, output logic [18:0] d);
        log_rd_tid = 2'(t);
        #1;
        d = log_rd_data;
    endtask

    task automatic check_all(input string tag);
        logic [18:0] d;
        bit exp_vld;
        logic [3:0] exp_hit;
        exp_vld = (q.size() > 0) && mlog[q[0]].vld;
        check({tag, " rpt_vld"}, 32'(rif.rpt_vld), 32'(exp_vld));
        if (exp_vld) begin
            check({tag, " rpt_tid"}, 32'(rif.rpt_tid), 32'(q[0]));
            check({tag, " rpt_ue"}, 32'(rif.rpt_ue), 32'(mlog[q[0]].ue));
        end
        for (int t = 0; t < 4; t++) begin
            read_log(t, d);
            check($sformatf("%s log%0d", tag, t), 32'(d),
                  32'({mlog[t].vld, mlog[t].ue, mlog[t].me, mlog[t].rg, mlog[t].synd}));
            exp_hit[t] = (mcnt[t] >= 8);
        end
        check({tag, " thresh"}, 32'(ce_thresh_hit), 32'(exp_hit));
    endtask

    // Reset is asserted: every output must read 0 at once.
    task automatic check_reset_zero(input string tag);
        logic [18:0] d;
        check({tag, " rpt_vld"}, 32'(rif.rpt_vld), 32'h0);
        check({tag, " rpt_tid"}, 32'(rif.rpt_tid), 32'h0);
        check({tag, " rpt_ue"}, 32'(rif.rpt_ue), 32'h0);
        check({tag, " thresh"}, 32'(ce_thresh_hit), 32'h0);
        for (int t = 0; t < 4; t++) begin
            read_log(t, d);
            check($sformatf("%s log%0d", tag, t), 32'(d), 32'h0);
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_m(input bit ce, input bit ue, input bit [7:0] rg,
                         input bit [7:0] sy, input bit [1:0] tid);
        ce_m = ce; ue_m = ue; err_reg_m = rg; synd7_m = sy[7]; synd_m = sy[6:0];
        tid_m = tid;
    endtask

    task automatic idle_m();
        ce_m = 1'b0; ue_m = 1'b0;
    endtask

    logic [18:0] rd;

    initial begin
        arst_l = 1'b0;
        ce_m = 0; ue_m = 0; err_reg_m = 0; synd7_m = 0; synd_m = 0; tid_m = 0;
        flush_w = 0; clr_vld = 0; clr_tid = 0; log_rd_tid = 0; rif.rpt_rdy = 1'b0;
        model_reset();
        #2;
        check_reset_zero("reset");
        @(negedge clk);
        arst_l = 1'b1;
        step("post_reset");

        // CE on tid 2 is reported two cycles after M.
        rif.rpt_rdy = 1'b1;
        set_m(1, 0, 8'h4B, 8'h93, 2'd2);
        step("t1_m");
        idle_m();
        step("t1_w");
        check("t1 rpt_vld", 32'(rif.rpt_vld), 32'h1);
        check("t1 rpt_tid", 32'(rif.rpt_tid), 32'h2);
        check("t1 rpt_ue", 32'(rif.rpt_ue), 32'h0);
        read_log(2, rd);
        check("t1 log2", 32'(rd), 32'({1'b1, 1'b0, 1'b0, 8'h4B, 8'h93}));
        step("t1_drain");

        // CE then UE on tid 1 while the IFU stalls: one entry, rpt_ue flips.
        rif.rpt_rdy = 1'b0;
        set_m(1, 0, 8'h11, 8'h85, 2'd1);
        step("t2_ce");
        set_m(0, 1, 8'h22, 8'h07, 2'd1);
        step("t2_ue");
        idle_m();
        check("t2 ue before", 32'(rif.rpt_ue), 32'h0);
        step("t2_upg");
        check("t2 ue after", 32'(rif.rpt_ue), 32'h1);
        read_log(1, rd);
        check("t2 log1", 32'(rd), 32'({1'b1, 1'b1, 1'b1, 8'h22, 8'h07}));
        set_m(1, 0, 8'h33, 8'hFF, 2'd1);
        step("t2_ce3");
        idle_m();
        step("t2_ce3w");
        read_log(1, rd);
        check("t2 log1 held", 32'(rd), 32'({1'b1, 1'b1, 1'b1, 8'h22, 8'h07}));
        rif.rpt_rdy = 1'b1;
        step("t2_drain");
        check("t2 single entry", 32'(rif.rpt_vld), 32'h0);

        // A flushed UE on tid 0 leaves no trace.
        set_m(0, 1, 8'h5C, 8'h12, 2'd0);
        step("t3_m");
        idle_m();
        flush_w = 1'b1;
        step("t3_w");
        flush_w = 1'b0;
        step("t3_after");
        read_log(0, rd);
        check("t3 log0", 32'(rd), 32'h0);
        check("t3 rpt_vld", 32'(rif.rpt_vld), 32'h0);

        // 20 CEs on tid 3: the counter saturates, the threshold bit rises, then clear.
        for (int i = 0; i < 20; i++) begin
            set_m(1, 0, 8'(i), 8'h80 | 8'(i), 2'd3);
            step($sformatf("t4_ce%0d", i));
        end
        idle_m();
        step("t4_idle0");
        step("t4_idle1");
        check("t4 hit3", 32'(ce_thresh_hit[3]), 32'h1);
        clr_vld = 1'b1; clr_tid = 2'd3;
        step("t4_clr");
        clr_vld = 1'b0;
        check("t4 hit3 clr", 32'(ce_thresh_hit[3]), 32'h0);

        // Clear every log, then queue 4 threads and drain them in order.
        rif.rpt_rdy = 1'b0;
        for (int t = 0; t < 4; t++) begin
            clr_vld = 1'b1; clr_tid = 2'(t);
            step($sformatf("t5_clr%0d", t));
        end
        clr_vld = 1'b0;
        for (int t = 0; t < 4; t++) begin
            set_m(1, 0, 8'h10 + 8'(t), 8'hA0 + 8'(t), 2'(t));
            step($sformatf("t5_ce%0d", t));
        end
        idle_m();
        step("t5_fill");
        rif.rpt_rdy = 1'b1;
        for (int t = 0; t < 4; t++) begin
            check($sformatf("t5 order vld%0d", t), 32'(rif.rpt_vld), 32'h1);
            check($sformatf("t5 order tid%0d", t), 32'(rif.rpt_tid), 32'(t));
            step($sformatf("t5_pop%0d", t));
        end
        check("t5 empty", 32'(rif.rpt_vld), 32'h0);

        // A cleared head is dropped without a report.
        rif.rpt_rdy = 1'b0;
        clr_vld = 1'b1; clr_tid = 2'd2;
        step("t6_preclr");
        clr_vld = 1'b0;
        set_m(1, 0, 8'h44, 8'h81, 2'd2);
        step("t6_ce");
        idle_m();
        step("t6_q");
        check("t6 queued", 32'(rif.rpt_vld), 32'h1);
        clr_vld = 1'b1; clr_tid = 2'd2;
        step("t6_clr");
        clr_vld = 1'b0;
        check("t6 stale", 32'(rif.rpt_vld), 32'h0);
        step("t6_pop");

        // A CE in W during a clear of the same thread is a fresh capture.
        set_m(1, 0, 8'h60, 8'h01, 2'd2);
        step("t7_ce");
        idle_m();
        step("t7_q");
        rif.rpt_rdy = 1'b1;
        step("t7_drain");
        rif.rpt_rdy = 1'b0;
        set_m(1, 0, 8'h5A, 8'h3C, 2'd2);
        step("t7_ce2");
        idle_m();
        clr_vld = 1'b1; clr_tid = 2'd2;
        step("t7_clr");
        clr_vld = 1'b0;
        read_log(2, rd);
        check("t7 log2", 32'(rd), 32'({1'b1, 1'b0, 1'b0, 8'h5A, 8'h3C}));
        check("t7 rpt_vld", 32'(rif.rpt_vld), 32'h1);
        check("t7 rpt_tid", 32'(rif.rpt_tid), 32'h2);

        // Reset while entries are queued.
        set_m(0, 1, 8'h77, 8'h55, 2'd0);
        step("t8_ue");
        idle_m();
        step("t8_q");
        arst_l = 1'b0;
        #1;
        model_reset();
        check_reset_zero("t8_reset");
        @(negedge clk);
        arst_l = 1'b1;
        step("t8_post");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            ce_m      = ($urandom_range(99) < 30);
            ue_m      = ($urandom_range(99) < 12);
            err_reg_m = 8'($urandom);
            synd7_m   = 1'($urandom);
            synd_m    = 7'($urandom);
            tid_m     = 2'($urandom);
            flush_w   = ($urandom_range(99) < 10);
            clr_vld   = ($urandom_range(99) < 5);
            clr_tid   = 2'($urandom);
            rif.rpt_rdy = ($urandom_range(99) < 50);
            step($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
